vga_timing_gen: RTL

- Parametrised VGA/SVGA raster timing generator. Successor to the fixed 800x600 controller.
- Generates horizontal/vertical counters, sync pulses with programmable polarity, and a look-ahead pixel request with coordinates. The request lets a pixel source with fixed read latency (ROM, line buffer, character generator) supply data.
- Delays sync and data-enable by the same latency so colour and syncs arrive aligned at the DAC pins.
- Adds a run/stop control that starts and stops only on frame boundaries, plus frame/line strobes and a frame counter.

---
 rtl/vga_timing_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with look-ahead pixel request,
// latency-matched sync/DE output pipeline and frame-aligned run/stop control.
module vga_timing_gen #(
    parameter int unsigned H_SYNC  = 128,
    parameter int unsigned H_BACK  = 88,
    parameter int unsigned H_VALID = 800,
    parameter int unsigned H_FRONT = 40,
    parameter int unsigned V_SYNC  = 4,
    parameter int unsigned V_BACK  = 23,
    parameter int unsigned V_VALID = 600,
    parameter int unsigned V_FRONT = 1,
    parameter bit          H_POL   = 1'b1,
    parameter bit          V_POL   = 1'b1,
    parameter int unsigned RGB_W   = 3,
    parameter int unsigned CNT_W   = 11,
    parameter int unsigned PIX_LAT = 2
) (
    input  logic             vga_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic [RGB_W-1:0] pix_data,
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             line_start,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [RGB_W-1:0] vga_rgb,
    output logic             running,
    output logic [15:0]      frame_cnt
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_OFS  = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] V_OFS  = CNT_W'(V_SYNC + V_BACK);

    // One extra bit so an active region ending exactly at 2^CNT_W still compares correctly.
    localparam logic [CNT_W:0] H_SYNC_END = (CNT_W+1)'(H_SYNC);
    localparam logic [CNT_W:0] V_SYNC_END = (CNT_W+1)'(V_SYNC);
    localparam logic [CNT_W:0] H_ACT_BEG  = (CNT_W+1)'(H_SYNC + H_BACK);
    localparam logic [CNT_W:0] H_ACT_END  = (CNT_W+1)'(H_SYNC + H_BACK + H_VALID);
    localparam logic [CNT_W:0] V_ACT_BEG  = (CNT_W+1)'(V_SYNC + V_BACK);
    localparam logic [CNT_W:0] V_ACT_END  = (CNT_W+1)'(V_SYNC + V_BACK + V_VALID);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOPPING
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_h_q;
    logic [CNT_W-1:0] cnt_v_q;
    logic [15:0]      frame_cnt_q;

    logic h_end;
    logic frame_end;

    assign h_end     = (cnt_h_q == H_LAST);
    assign frame_end = h_end && (cnt_v_q == V_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            cnt_h_q     <= '0;
            cnt_v_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_h_q <= '0;
                    cnt_v_q <= '0;
                    if (en) state_q <= S_RUN;
                end
                S_RUN, S_STOPPING: begin
                    cnt_h_q <= h_end ? '0 : cnt_h_q + 1'b1;
                    if (h_end) cnt_v_q <= (cnt_v_q == V_LAST) ? '0 : cnt_v_q + 1'b1;
                    if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
                    // Stopping only takes effect at the last pixel of a frame.
                    if (en) state_q <= S_RUN;
                    else if (state_q == S_RUN) state_q <= S_STOPPING;
                    else if (frame_end) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic h_act;
    logic v_act;
    logic hs_raw;
    logic vs_raw;

    assign running     = (state_q != S_IDLE);
    assign h_act       = ({1'b0, cnt_h_q} >= H_ACT_BEG) && ({1'b0, cnt_h_q} < H_ACT_END);
    assign v_act       = ({1'b0, cnt_v_q} >= V_ACT_BEG) && ({1'b0, cnt_v_q} < V_ACT_END);
    assign pix_req     = running && h_act && v_act;
    assign pix_x       = pix_req ? cnt_h_q - H_OFS : '0;
    assign pix_y       = pix_req ? cnt_v_q - V_OFS : '0;
    assign line_start  = running && (cnt_h_q == '0);
    assign frame_start = line_start && (cnt_v_q == '0);
    assign hs_raw      = (running && ({1'b0, cnt_h_q} < H_SYNC_END)) ? H_POL : ~H_POL;
    assign vs_raw      = (running && ({1'b0, cnt_v_q} < V_SYNC_END)) ? V_POL : ~V_POL;
    assign frame_cnt   = frame_cnt_q;

    // Raw sync/DE delayed by PIX_LAT to line up with pix_data arriving from the source.
    logic hsync_d;
    logic vsync_d;
    logic de_d;

    if (PIX_LAT == 0) begin : g_no_lat
        assign hsync_d = hs_raw;
        assign vsync_d = vs_raw;
        assign de_d    = pix_req;
    end else begin : g_lat
        logic [PIX_LAT-1:0] hs_sr_q;
        logic [PIX_LAT-1:0] vs_sr_q;
        logic [PIX_LAT-1:0] de_sr_q;

        // NOTE: the delay line is reset to inactive levels so nothing spurious reaches the pins after reset.
        always_ff @(posedge vga_clk or posedge sys_rst) begin
            if (sys_rst) begin
                hs_sr_q <= {PIX_LAT{~H_POL}};
                vs_sr_q <= {PIX_LAT{~V_POL}};
                de_sr_q <= '0;
            end else begin
                hs_sr_q[0] <= hs_raw;
                vs_sr_q[0] <= vs_raw;
                de_sr_q[0] <= pix_req;
                for (int i = 1; i < PIX_LAT; i++) begin
                    hs_sr_q[i] <= hs_sr_q[i-1];
                    vs_sr_q[i] <= vs_sr_q[i-1];
                    de_sr_q[i] <= de_sr_q[i-1];
                end
            end
        end

        assign hsync_d = hs_sr_q[PIX_LAT-1];
        assign vsync_d = vs_sr_q[PIX_LAT-1];
        assign de_d    = de_sr_q[PIX_LAT-1];
    end

    logic             hsync_q;
    logic             vsync_q;
    logic             de_q;
    logic [RGB_W-1:0] rgb_q;

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            de_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            rgb_q   <= de_d ? pix_data : '0;
        end
    end

    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign de      = de_q;
    assign vga_rgb = rgb_q;

endmodule
